// File: rtl/bin2bcd_iter_conv.sv
// Iterative double-dabble binary-to-BCD converter with valid/ready handshakes, stall and abort.
// Define BIN2BCD_PAR_ADJ_EN to adjust all digits in one cycle instead of one digit per cycle.
`timescale 1ns/1ps
module bin2bcd_iter_conv #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_ovf,
  output logic                busy
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int BCW   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [BIN_W-1:0] bin_reg, bin_next;
  logic [BCD_W-1:0] bcd_reg, bcd_next, bcd_adj;
  logic             ovf_reg, ovf_next;
  logic [BCW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic             adj_last;

  genvar gi;

`ifdef BIN2BCD_PAR_ADJ_EN
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_par_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                               : bcd_reg[4*gi +: 4];
    end
  endgenerate
  assign adj_last = 1'b1;
`else
  localparam int DCW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DCW-1:0] DIG_LAST = DCW'(DIGITS - 1);

  logic [DCW-1:0] dig_cnt_reg, dig_cnt_next;
  logic [3:0]     dig_cur, dig_sum;

  // One adder shared by all digits: select, adjust, write back to the same slot.
  always_comb begin
    dig_cur = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_cnt_reg == DCW'(i)) dig_cur = bcd_reg[4*i +: 4];
    end
  end

  assign dig_sum = (dig_cur >= 4'd5) ? dig_cur + 4'd3 : dig_cur;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_ser_wr
      assign bcd_adj[4*gi +: 4] = (dig_cnt_reg == DCW'(gi)) ? dig_sum : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign adj_last = (dig_cnt_reg == DIG_LAST);

  always_comb begin
    dig_cnt_next = dig_cnt_reg;
    if (clear) begin
      dig_cnt_next = '0;
    end else if (en) begin
      case (state_reg)
        ADJ:     if (!adj_last) dig_cnt_next = dig_cnt_reg + 1'b1;
        default: dig_cnt_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dig_cnt_reg <= '0;
    else        dig_cnt_reg <= dig_cnt_next;
  end
`endif

  always_comb begin
    state_next   = state_reg;
    bin_next     = bin_reg;
    bcd_next     = bcd_reg;
    ovf_next     = ovf_reg;
    bit_cnt_next = bit_cnt_reg;
    if (clear) begin
      state_next   = IDLE;
      bin_next     = '0;
      bcd_next     = '0;
      ovf_next     = 1'b0;
      bit_cnt_next = '0;
    end else if (en) begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_next   = ADJ;
            bin_next     = in_bin;
            bcd_next     = '0;
            ovf_next     = 1'b0;
            bit_cnt_next = '0;
          end
        end
        ADJ: begin
          bcd_next = bcd_adj;
          if (adj_last) state_next = SHIFT;
        end
        SHIFT: begin
          // Anything pushed out of the top digit means the value needs more digits.
          bcd_next = {bcd_reg[BCD_W-2:0], bin_reg[BIN_W-1]};
          bin_next = {bin_reg[BIN_W-2:0], 1'b0};
          ovf_next = ovf_reg | bcd_reg[BCD_W-1];
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = DONE;
          end else begin
            state_next   = ADJ;
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bin_reg     <= '0;
      bcd_reg     <= '0;
      ovf_reg     <= 1'b0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bin_reg     <= bin_next;
      bcd_reg     <= bcd_next;
      ovf_reg     <= ovf_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == ADJ) || (state_reg == SHIFT);
  assign out_bcd   = bcd_reg;
  assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_bin2bcd_iter_conv.sv
// Directed bench: a 5-digit and a 4-digit converter share control inputs and are checked
// against hand-computed BCD results, latency, back-pressure, stall, clear and reset.
`timescale 1ns/1ps
module tb_bin2bcd_iter_conv;
  localparam int BIN_W = 16;
`ifdef BIN2BCD_PAR_ADJ_EN
  localparam int N5 = 2 * BIN_W;
  localparam int N4 = 2 * BIN_W;
`else
  localparam int N5 = BIN_W * 6;
  localparam int N4 = BIN_W * 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_bin = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_ovf, busy;
  logic [19:0] out_bcd;
  logic        in_ready_4, out_valid_4, out_ovf_4, busy_4;
  logic [15:0] out_bcd_4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bin2bcd_iter_conv #(.BIN_W(16), .DIGITS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_ovf(out_ovf), .busy(busy)
  );

  bin2bcd_iter_conv #(.BIN_W(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_4), .in_bin(in_bin),
    .out_valid(out_valid_4), .out_ready(out_ready), .out_bcd(out_bcd_4),
    .out_ovf(out_ovf_4), .busy(busy_4)
  );

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd5;
    logic        ovf5;
    logic [15:0] bcd4;
    logic        ovf4;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] val);
    int g;
    g = 0;
    @(negedge clk);
    while (!(in_ready && in_ready_4) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) begin
      total++;
      bad++;
      $display("FAIL start_timeout: in_ready=%b in_ready_4=%b, expected both 1", in_ready, in_ready_4);
    end
    in_valid = 1'b1;
    in_bin   = val;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called right after the accept edge; k counts clock edges since then.
  task automatic wait_done(input int stall_at, input int stall_len,
                           output logic [19:0] b5, output logic o5, output int l5,
                           output logic [15:0] b4, output logic o4, output int l4);
    int k;
    k = 0; l5 = -1; l4 = -1; b5 = '0; o5 = 1'b0; b4 = '0; o4 = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && l5 < 0) begin l5 = k; b5 = out_bcd; o5 = out_ovf; end
      if (out_valid_4 && l4 < 0) begin l4 = k; b4 = out_bcd_4; o4 = out_ovf_4; end
      if ((l5 >= 0 && l4 >= 0) || k > 400) break;
      if (stall_len > 0 && k == stall_at) en = 1'b0;
      if (stall_len > 0 && k == stall_at + stall_len) en = 1'b1;
      k++;
    end
    en = 1'b1;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] b5;
    logic [15:0] b4;
    logic        o5, o4;
    int          l5, l4;

    vecs[0] = '{16'hFFFF,   20'h65535, 1'b0, 16'h5535, 1'b1};
    vecs[1] = '{16'd0,      20'h00000, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{16'd9999,   20'h09999, 1'b0, 16'h9999, 1'b0};
    vecs[3] = '{16'd10,     20'h00010, 1'b0, 16'h0010, 1'b0};
    vecs[4] = '{16'd12345,  20'h12345, 1'b0, 16'h2345, 1'b1};
    vecs[5] = '{16'd10000,  20'h10000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'd1,      20'h00001, 1'b0, 16'h0001, 1'b0};
    vecs[7] = '{16'd4321,   20'h04321, 1'b0, 16'h4321, 1'b0};
    vecs[8] = '{16'd50505,  20'h50505, 1'b0, 16'h0505, 1'b1};
    vecs[9] = '{16'd255,    20'h00255, 1'b0, 16'h0255, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_bcd", {12'd0, out_bcd}, 32'd0);
    rst_n = 1'b1;

    // Table-driven conversions
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].bin);
      wait_done(-1, 0, b5, o5, l5, b4, o4, l4);
      $display("conv in=%0d d5 bcd=%h ovf=%b lat=%0d d4 bcd=%h ovf=%b lat=%0d",
               vecs[i].bin, b5, o5, l5, b4, o4, l4);
      check("bcd5", {12'd0, b5}, {12'd0, vecs[i].bcd5});
      check("ovf5", {31'd0, o5}, {31'd0, vecs[i].ovf5});
      check("lat5", l5, N5);
      check("bcd4", {16'd0, b4}, {16'd0, vecs[i].bcd4});
      check("ovf4", {31'd0, o4}, {31'd0, vecs[i].ovf4});
      check("lat4", l4, N4);
      ack();
    end

    // in_valid in IDLE with en=0 is not accepted
    @(negedge clk);
    en = 1'b0; in_valid = 1'b1; in_bin = 16'd123;
    repeat (3) @(negedge clk);
    check("stall_idle_busy", {31'd0, busy}, 32'd0);
    check("stall_idle_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0; en = 1'b1;
    @(negedge clk);
    check("stall_idle_after", {31'd0, busy}, 32'd0);
    $display("seq idle_en0 busy=%b in_ready=%b", busy, in_ready);

    // Back-pressure: operand pulses while busy and while holding a result are ignored
    start_op(16'd4321);
    repeat (5) @(negedge clk);
    in_valid = 1'b1; in_bin = 16'd999;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(-1, 0, b5, o5, l5, b4, o4, l4);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin in_valid = 1'b1; in_bin = 16'd777; end
      if (c == 5) in_valid = 1'b0;
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_bcd", {12'd0, out_bcd}, 32'h04321);
      check("hold_ovf", {31'd0, out_ovf}, 32'd0);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    ack();
    @(negedge clk);
    check("post_ack_ready", {31'd0, in_ready}, 32'd1);
    check("post_ack_valid", {31'd0, out_valid}, 32'd0);
    check("post_ack_busy", {31'd0, busy}, 32'd0);
    $display("seq backpressure bcd=%h in_ready=%b busy=%b", out_bcd, in_ready, busy);

    // Stall for 7 cycles mid-conversion
    start_op(16'hFFFF);
    wait_done(20, 7, b5, o5, l5, b4, o4, l4);
    $display("conv stall in=65535 d5 bcd=%h lat=%0d d4 bcd=%h lat=%0d", b5, l5, b4, l4);
    check("stall_bcd5", {12'd0, b5}, 32'h65535);
    check("stall_lat5", l5, N5 + 7);
    check("stall_bcd4", {16'd0, b4}, 32'h5535);
    check("stall_lat4", l4, N4 + 7);
    ack();

    // Clear at cycle 20 of a conversion
    start_op(16'hFFFF);
    repeat (20) @(negedge clk);
    check("pre_clear_busy", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_ready", {31'd0, in_ready}, 32'd1);
    check("clear_valid", {31'd0, out_valid}, 32'd0);
    check("clear_busy", {31'd0, busy}, 32'd0);
    check("clear_ready4", {31'd0, in_ready_4}, 32'd1);
    start_op(16'd4321);
    wait_done(-1, 0, b5, o5, l5, b4, o4, l4);
    $display("conv after_clear in=4321 bcd=%h ovf=%b", b5, o5);
    check("clear_next_bcd", {12'd0, b5}, 32'h04321);
    check("clear_next_ovf", {31'd0, o5}, 32'd0);
    ack();

    // Reset at cycle 20 of a conversion
    start_op(16'hFFFF);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_bcd", {12'd0, out_bcd}, 32'd0);
    rst_n = 1'b1;
    start_op(16'd4321);
    wait_done(-1, 0, b5, o5, l5, b4, o4, l4);
    $display("conv after_rst in=4321 bcd=%h ovf=%b", b5, o5);
    check("rst_next_bcd", {12'd0, b5}, 32'h04321);
    check("rst_next_lat", l5, N5);
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
